// File: rtl/cordic_rot_to_float_pkg.sv
// rtl/cordic_rot_to_float_pkg.sv - shared widths and CORDIC constants for the cosine datapath
package cordic_rot_to_float_pkg;

    localparam int W     = 21;
    localparam int IDX_W = 4;

    localparam logic [W-1:0] CORDIC_K = 21'h09B74E;

    // atan(2^-i) in Q1.20; beyond i=7 the angle equals 2^-i to within Q1.20 resolution
    function automatic logic [W-1:0] atan_lut(input logic [IDX_W-1:0] idx);
        logic [W-1:0] a;
        case (idx)
            4'd0:    a = 21'h0C90FE;
            4'd1:    a = 21'h076B1A;
            4'd2:    a = 21'h03EB6F;
            4'd3:    a = 21'h01FD5C;
            4'd4:    a = 21'h00FFAB;
            4'd5:    a = 21'h007FF5;
            4'd6:    a = 21'h003FFF;
            4'd7:    a = 21'h002000;
            default: a = 21'h100000 >> idx;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_rot_to_float_f2f.sv
// rtl/cordic_rot_to_float_f2f.sv - exact Q1.20 to IEEE-754 single conversion
module fixed_to_float
    import cordic_rot_to_float_pkg::*;
(
    input  logic [W-1:0] in,
    output logic [31:0]  out
);

    logic [W-1:0] mag;
    logic [4:0]   p;
    logic [23:0]  norm;
    logic [7:0]   expo;

    assign mag = in[W-1] ? (~in + 1'b1) : in;

    always_comb begin
        p = 5'd0;
        for (int k = 0; k < W; k++) begin
            if (mag[k]) p = 5'(k);
        end
    end

    // place the leading one at bit 23 so the fraction sits in bits 22..0
    assign norm = {3'b000, mag} << (5'd23 - p);
    assign expo = 8'd107 + {3'b000, p};

    always_comb begin
        if (mag == '0) out = 32'h0000_0000;
        else           out = {in[W-1], expo, norm[22:0]};
    end

endmodule

// File: rtl/cordic_rot_to_float_rot.sv
// rtl/cordic_rot_to_float_rot.sv - one combinational rotation-mode CORDIC micro-rotation
module cordic_rot
    import cordic_rot_to_float_pkg::*;
(
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic [W-1:0]     z,
    input  logic [IDX_W-1:0] rotate_index,
    input  logic [W-1:0]     rotate_angle,
    output logic [W-1:0]     rot_x,
    output logic [W-1:0]     rot_y,
    output logic [W-1:0]     rot_z
);

    logic signed [W-1:0] xs;
    logic signed [W-1:0] ys;
    logic [W-1:0]        x_sh;
    logic [W-1:0]        y_sh;
    logic                d_pos;

    assign xs    = x;
    assign ys    = y;
    assign x_sh  = xs >>> rotate_index;
    assign y_sh  = ys >>> rotate_index;
    // a zero residual angle rotates in the positive direction
    assign d_pos = ~z[W-1];

    always_comb begin
        if (d_pos) begin
            rot_x = x - y_sh;
            rot_y = y + x_sh;
            rot_z = z - rotate_angle;
        end else begin
            rot_x = x + y_sh;
            rot_y = y - x_sh;
            rot_z = z + rotate_angle;
        end
    end

endmodule

// File: rtl/cordic_rot_to_float.sv
// rtl/cordic_rot_to_float.sv - registered CORDIC step with float view of the new x
module cordic_rot_to_float
    import cordic_rot_to_float_pkg::*;
(
    input  logic             clock,
    input  logic             aclr,
    input  logic             clk_en,
    input  logic             in_valid,
    input  logic [W-1:0]     x_in,
    input  logic [W-1:0]     y_in,
    input  logic [W-1:0]     z_in,
    input  logic [IDX_W-1:0] rotate_index,
    input  logic [W-1:0]     rotate_angle,
    output logic [W-1:0]     rot_x,
    output logic [W-1:0]     rot_y,
    output logic [W-1:0]     rot_z,
    output logic [31:0]      result,
    output logic             out_valid
);

    logic [W-1:0] rot_x_d, rot_y_d, rot_z_d;
    logic [W-1:0] rot_x_q, rot_y_q, rot_z_q;
    logic         valid_q;

    cordic_rot u_rot (
        .x            (x_in),
        .y            (y_in),
        .z            (z_in),
        .rotate_index (rotate_index),
        .rotate_angle (rotate_angle),
        .rot_x        (rot_x_d),
        .rot_y        (rot_y_d),
        .rot_z        (rot_z_d)
    );

    always_ff @(posedge clock) begin
        if (aclr) begin
            rot_x_q <= '0;
            rot_y_q <= '0;
            rot_z_q <= '0;
            valid_q <= 1'b0;
        end else if (clk_en) begin
            valid_q <= in_valid;
            if (in_valid) begin
                rot_x_q <= rot_x_d;
                rot_y_q <= rot_y_d;
                rot_z_q <= rot_z_d;
            end
        end
    end

    fixed_to_float u_f2f (
        .in  (rot_x_q),
        .out (result)
    );

    assign rot_x     = rot_x_q;
    assign rot_y     = rot_y_q;
    assign rot_z     = rot_z_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_cordic_rot_to_float.sv
// tb/tb_cordic_rot_to_float.sv - directed self-checking bench with a reference model
module tb_cordic_rot_to_float;

    logic        clock = 1'b0;
    logic        aclr, clk_en, in_valid;
    logic [20:0] x_in, y_in, z_in, rotate_angle;
    logic [3:0]  rotate_index;
    logic [20:0] rot_x, rot_y, rot_z;
    logic [31:0] result;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    logic [20:0] m_x, m_y, m_z;
    logic        m_v;
    logic        started = 1'b0;

    cordic_rot_to_float dut (
        .clock        (clock),
        .aclr         (aclr),
        .clk_en       (clk_en),
        .in_valid     (in_valid),
        .x_in         (x_in),
        .y_in         (y_in),
        .z_in         (z_in),
        .rotate_index (rotate_index),
        .rotate_angle (rotate_angle),
        .rot_x        (rot_x),
        .rot_y        (rot_y),
        .rot_z        (rot_z),
        .result       (result),
        .out_valid    (out_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [62:0] model_rot(input logic [20:0] x, input logic [20:0] y,
                                              input logic [20:0] z, input int i,
                                              input logic [20:0] ang);
        int xi, yi, zi, ai, nx, ny, nz;
        xi = int'($signed(x));
        yi = int'($signed(y));
        zi = int'($signed(z));
        ai = int'($signed(ang));
        if (zi >= 0) begin
            nx = xi - (yi >>> i);
            ny = yi + (xi >>> i);
            nz = zi - ai;
        end else begin
            nx = xi + (yi >>> i);
            ny = yi - (xi >>> i);
            nz = zi + ai;
        end
        return {21'(nx), 21'(ny), 21'(nz)};
    endfunction

    function automatic logic [31:0] model_float(input logic [20:0] v);
        real         r;
        logic [63:0] b;
        int          e;
        if (v == 21'h0) return 32'h0;
        r = real'(int'($signed(v))) / 1048576.0;
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    always @(posedge clock) begin
        logic [62:0] r;
        r = model_rot(x_in, y_in, z_in, int'(rotate_index), rotate_angle);
        if (aclr) begin
            m_x <= '0; m_y <= '0; m_z <= '0; m_v <= 1'b0;
            started <= 1'b1;
        end else if (clk_en) begin
            m_v <= in_valid;
            if (in_valid) begin
                m_x <= r[62:42]; m_y <= r[41:21]; m_z <= r[20:0];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            check("cmp_valid", 32'(out_valid), 32'(m_v));
            check("cmp_rot_x", 32'(rot_x), 32'(m_x));
            check("cmp_rot_y", 32'(rot_y), 32'(m_y));
            check("cmp_rot_z", 32'(rot_z), 32'(m_z));
            check("cmp_result", result, model_float(m_x));
        end
    end

    task automatic step(input logic rst, input logic en, input logic vld,
                        input logic [20:0] x, input logic [20:0] y, input logic [20:0] z,
                        input logic [3:0] i, input logic [20:0] ang);
        aclr = rst; clk_en = en; in_valid = vld;
        x_in = x; y_in = y; z_in = z; rotate_index = i; rotate_angle = ang;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [20:0] ex,
                              input logic [20:0] ey, input logic [20:0] ez, input logic [31:0] er);
        check({name, "_valid"}, 32'(out_valid), 32'(v));
        check({name, "_x"}, 32'(rot_x), 32'(ex));
        check({name, "_y"}, 32'(rot_y), 32'(ey));
        check({name, "_z"}, 32'(rot_z), 32'(ez));
        check({name, "_result"}, result, er);
    endtask

    logic [20:0] corner_in [4]  = '{21'h000001, 21'h1FFFFF, 21'h100000, 21'h0FFFFF};
    logic [31:0] corner_exp [4] = '{32'h35800000, 32'hB5800000, 32'hBF800000, 32'h3F7FFFF0};

    initial begin
        aclr = 1'b0; clk_en = 1'b0; in_valid = 1'b0;
        x_in = '0; y_in = '0; z_in = '0; rotate_index = '0; rotate_angle = '0;
        #2;

        step(1'b1, 1'b0, 1'b0, 21'h0, 21'h0, 21'h0, 4'd0, 21'h0);
        expect_out("reset", 1'b0, 21'h0, 21'h0, 21'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 21'h09B74E, 21'h0, 21'h0C90FE, 4'd0, 21'h0C90FE);
        step(1'b0, 1'b0, 1'b1, 21'h09B74E, 21'h0, 21'h0C90FE, 4'd0, 21'h0C90FE);
        expect_out("hold_after_reset", 1'b0, 21'h0, 21'h0, 21'h0, 32'h0);

        step(1'b0, 1'b1, 1'b1, 21'h09B74E, 21'h0, 21'h0C90FE, 4'd0, 21'h0C90FE);
        expect_out("pos_rot", 1'b1, 21'h09B74E, 21'h09B74E, 21'h0, 32'h3F1B74E0);
        step(1'b0, 1'b0, 1'b0, 21'h0, 21'h0, 21'h0, 4'd0, 21'h0);
        expect_out("en_low_hold", 1'b1, 21'h09B74E, 21'h09B74E, 21'h0, 32'h3F1B74E0);
        step(1'b0, 1'b1, 1'b0, 21'h012345, 21'h0, 21'h0, 4'd3, 21'h0);
        expect_out("invalid_hold", 1'b0, 21'h09B74E, 21'h09B74E, 21'h0, 32'h3F1B74E0);

        step(1'b0, 1'b1, 1'b1, 21'h09B74E, 21'h0, 21'h136F02, 4'd0, 21'h0C90FE);
        check("neg_rot_x", 32'(rot_x), 32'h09B74E);
        check("neg_rot_y", 32'(rot_y), 32'h1648B2);
        check("neg_rot_z", 32'(rot_z), 32'h0);

        step(1'b0, 1'b1, 1'b1, 21'h080000, 21'h0, 21'h000100, 4'd1, 21'h076B1A);
        expect_out("shift1", 1'b1, 21'h080000, 21'h040000, 21'h1895E6, 32'h3F000000);

        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1, corner_in[k], 21'h0, 21'h0, 4'd5, 21'h0);
            check($sformatf("corner%0d", k), result, corner_exp[k]);
        end

        step(1'b0, 1'b1, 1'b1, 21'h1ABCDE, 21'h054321, 21'h1F0000, 4'd15, 21'h000020);
        step(1'b0, 1'b1, 1'b1, 21'h0ABCDE, 21'h154321, 21'h010000, 4'd7, 21'h002000);

        step(1'b1, 1'b1, 1'b1, 21'h09B74E, 21'h0, 21'h0C90FE, 4'd0, 21'h0C90FE);
        expect_out("mid_reset", 1'b0, 21'h0, 21'h0, 21'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 21'h0, 21'h0, 21'h0, 4'd0, 21'h0);

        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
